button_event_queue: RTL and testbench

- Consumes the single-cycle `clean` press pulses from a bank of per-button debouncers.
- Turns simultaneous or back-to-back presses into an ordered stream of button-ID events.
- Buffers events in a small FIFO and presents them to the game/control FSM through a valid/ready handshake.
- Never back-pressures the debouncers. Events that cannot be stored are dropped and flagged.

---
 rtl/button_event_queue.sv | 123 ++++++++++++
 tb/tb_button_event_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_queue.sv
// button_event_queue
// Collects one-cycle press pulses from a bank of debouncers, serialises
// them lowest-index-first into button-ID events and buffers those events
// in a small first-word-fall-through FIFO with a valid/ready output.
// The debouncers are never stalled: events that find the FIFO full are
// dropped and the sticky overflow flag is raised.
// Optional build macro: BTN_EVENT_DROP_COUNT_EN adds an 8-bit saturating
// drop_count output that counts dropped events.
module button_event_queue #(
  parameter int NUM_BTN = 5,
  parameter int ID_W    = 3,
  parameter int ADDR_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_pulse,
  output logic               evt_valid,
  output logic [ID_W-1:0]    evt_id,
  input  logic               evt_ready,
  output logic [ADDR_W:0]    count,
  output logic               overflow,
  input  logic               overflow_clr
`ifdef BTN_EVENT_DROP_COUNT_EN
  ,
  output logic [7:0]         drop_count
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [NUM_BTN-1:0] pend;
  logic [NUM_BTN-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    mem [DEPTH];
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0]  wr_ptr;
  logic               full;
  logic               pop;
  logic               push_req;
  logic               push;
  logic               drop;

  // Lowest-index fixed-priority arbiter over the registered pending bits
  always_comb begin
    grant     = pend & (~pend + NUM_BTN'(1));
    grant_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pend[i]) begin
        grant_idx = ID_W'(i);
      end
    end
  end

  assign full      = (count == (ADDR_W + 1)'(DEPTH));
  assign evt_valid = (count != '0);
  assign evt_id    = evt_valid ? mem[rd_ptr] : '0;
  assign pop       = evt_valid & evt_ready;
  assign push_req  = |pend;
  assign push      = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

  // Pending presses: granted bit is retired, new pulses are merged in
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~grant) | btn_pulse;
    end
  end

  // Event storage; a full-with-pop write lands in the slot being read out
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= grant_idx;
    end
  end

  // Read/write pointers and occupancy count
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the clearing cycle keeps it set
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef BTN_EVENT_DROP_COUNT_EN
  // Saturating dropped-event counter; a drop while clearing restarts at 1
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (overflow_clr) begin
      drop_count <= drop ? 8'd1 : 8'd0;
    end else if (drop && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_button_event_queue.sv
// Testbench for button_event_queue: table-driven directed vectors,
// hand-written multi-cycle corner sequences and randomized stimulus,
// all compared against a queue-based reference model.
module tb_button_event_queue;

  logic       clk;
  logic       reset;
  logic [4:0] btn_pulse;
  logic       evt_valid;
  logic [2:0] evt_id;
  logic       evt_ready;
  logic [3:0] count;
  logic       overflow;
  logic       overflow_clr;
`ifdef BTN_EVENT_DROP_COUNT_EN
  logic [7:0] drop_count;
`endif

  int check_count = 0;
  int pass_count  = 0;

  // Reference model state: event list, pending presses, flags
  int         mq[$];
  logic [4:0] mpend;
  logic       movf;
  int         mdrop;

  typedef struct {
    logic [4:0] pulse;
    logic       ready;
    logic       exp_valid;
    logic [2:0] exp_id;
    logic [3:0] exp_count;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[16];

  button_event_queue dut (
    .clk          (clk),
    .reset        (reset),
    .btn_pulse    (btn_pulse),
    .evt_valid    (evt_valid),
    .evt_id       (evt_id),
    .evt_ready    (evt_ready),
    .count        (count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
`ifdef BTN_EVENT_DROP_COUNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Advance the reference model by one clock using the inputs of that cycle
  task automatic modelStep(input logic [4:0] p, input logic rdy,
                           input logic clr, input logic rst);
    int  g;
    bit  was_full;
    bit  popped;
    bit  dropped;
    if (rst) begin
      mq.delete();
      mpend = '0;
      movf  = 1'b0;
      mdrop = 0;
      return;
    end
    was_full = (mq.size() == 8);
    popped   = (mq.size() != 0) && rdy;
    dropped  = 1'b0;
    g = -1;
    for (int i = 0; i < 5; i++) begin
      if (mpend[i] && g < 0) g = i;
    end
    if (popped) void'(mq.pop_front());
    if (g >= 0) begin
      if (!was_full || popped) mq.push_back(g);
      else dropped = 1'b1;
      mpend[g] = 1'b0;
    end
    mpend = mpend | p;
    if (dropped) movf = 1'b1;
    else if (clr) movf = 1'b0;
    if (clr) mdrop = dropped ? 1 : 0;
    else if (dropped && mdrop < 255) mdrop = mdrop + 1;
  endtask

  // Drive one cycle of inputs, step the model, and sample after the edge
  task automatic applyStimulus(input logic [4:0] p, input logic rdy,
                               input logic clr, input logic rst);
    btn_pulse    = p;
    evt_ready    = rdy;
    overflow_clr = clr;
    reset        = rst;
    modelStep(p, rdy, clr, rst);
    @(posedge clk);
    #1;
  endtask

  // Compare the DUT outputs against one set of expected values
  task automatic checkOutput(input string name, input logic ev,
                             input logic [2:0] eid, input logic [3:0] ec,
                             input logic eo);
    check_count++;
    if (evt_valid === ev && evt_id === eid && count === ec && overflow === eo) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got valid=%0b id=%0d count=%0d ovf=%0b, expected valid=%0b id=%0d count=%0d ovf=%0b",
               name, evt_valid, evt_id, count, overflow, ev, eid, ec, eo);
    end
  endtask

  // Compare the DUT against the reference model's current view
  task automatic checkModel(input string name);
    logic [2:0] eid;
    eid = (mq.size() != 0) ? 3'(mq[0]) : 3'd0;
    checkOutput(name, mq.size() != 0, eid, 4'(mq.size()), movf);
`ifdef BTN_EVENT_DROP_COUNT_EN
    check_count++;
    if (drop_count === 8'(mdrop)) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s drop_count: got %0d, expected %0d", name, drop_count, mdrop);
    end
`endif
  endtask

  initial begin
    clk          = 1'b0;
    reset        = 1'b1;
    btn_pulse    = '0;
    evt_ready    = 1'b0;
    overflow_clr = 1'b0;
    mpend        = '0;
    movf         = 1'b0;
    mdrop        = 0;

    tbl[0]  = '{5'b00100, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0};
    tbl[1]  = '{5'b00000, 1'b1, 1'b1, 3'd2, 4'd1, 1'b0};
    tbl[2]  = '{5'b00000, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0};
    tbl[3]  = '{5'b11001, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0};
    tbl[4]  = '{5'b00000, 1'b1, 1'b1, 3'd0, 4'd1, 1'b0};
    tbl[5]  = '{5'b00000, 1'b1, 1'b1, 3'd3, 4'd1, 1'b0};
    tbl[6]  = '{5'b00000, 1'b1, 1'b1, 3'd4, 4'd1, 1'b0};
    tbl[7]  = '{5'b00000, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0};
    tbl[8]  = '{5'b10001, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0};
    tbl[9]  = '{5'b10000, 1'b1, 1'b1, 3'd0, 4'd1, 1'b0};
    tbl[10] = '{5'b00000, 1'b1, 1'b1, 3'd4, 4'd1, 1'b0};
    tbl[11] = '{5'b00000, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0};
    tbl[12] = '{5'b00010, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0};
    tbl[13] = '{5'b00010, 1'b1, 1'b1, 3'd1, 4'd1, 1'b0};
    tbl[14] = '{5'b00000, 1'b1, 1'b1, 3'd1, 4'd1, 1'b0};
    tbl[15] = '{5'b00000, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0};

    // Reset state
    applyStimulus(5'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(5'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset", 1'b0, 3'd0, 4'd0, 1'b0);
    checkModel("reset_model");

    // Directed table: single press, simultaneous presses, coalescing, re-arm
    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i].pulse, tbl[i].ready, 1'b0, 1'b0);
      checkOutput($sformatf("table[%0d]", i), tbl[i].exp_valid, tbl[i].exp_id,
                  tbl[i].exp_count, tbl[i].exp_ovf);
    end

    // Overflow: nine spaced presses on button 1 with the consumer stalled
    applyStimulus(5'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(5'b00010, 1'b0, 1'b0, 1'b0);
      checkModel("ovf_fill");
      applyStimulus(5'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(5'b0, 1'b0, 1'b0, 1'b0);
      checkModel("ovf_fill");
    end
    checkOutput("ovf_full", 1'b1, 3'd1, 4'd8, 1'b1);
`ifdef BTN_EVENT_DROP_COUNT_EN
    check_count++;
    if (drop_count === 8'd1) pass_count++;
    else $display("[TB] FAIL ovf_drop_count: got %0d, expected 1", drop_count);
`endif
    for (int k = 0; k < 8; k++) begin
      applyStimulus(5'b0, 1'b1, 1'b0, 1'b0);
      checkModel("ovf_drain");
    end
    checkOutput("ovf_drained", 1'b0, 3'd0, 4'd0, 1'b1);
    applyStimulus(5'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("ovf_clr", 1'b0, 3'd0, 4'd0, 1'b0);
    checkModel("ovf_clr_model");

    // Full FIFO with a pop in the same cycle as a grant
    applyStimulus(5'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(5'b00100, 1'b0, 1'b0, 1'b0);
      applyStimulus(5'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("full_before", 1'b1, 3'd2, 4'd8, 1'b0);
    applyStimulus(5'b01000, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("full_pop", 1'b1, 3'd2, 4'd8, 1'b0);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(5'b0, 1'b1, 1'b0, 1'b0);
      checkModel("full_pop_drain");
    end

    // Reset mid-operation with presses still in flight
    applyStimulus(5'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(5'b00001, 1'b0, 1'b0, 1'b0);
      applyStimulus(5'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("rst_queued", 1'b1, 3'd0, 4'd4, 1'b0);
    applyStimulus(5'b00011, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_mid", 1'b0, 3'd0, 4'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(5'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("rst_no_ghost", 1'b0, 3'd0, 4'd0, 1'b0);
    end

    // Randomized traffic against the model, alternating stalled/free consumer
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] p;
      logic       rdy;
      logic       clr;
      logic       rst;
      p   = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0;
      rdy = ((i / 400) % 2 == 0) ? ($urandom_range(0, 5) == 0)
                                 : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 40) == 0);
      rst = ($urandom_range(0, 700) == 0);
      applyStimulus(p, rdy, clr, rst);
      checkModel("random");
    end

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
